// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: control_info bundle from decode, the stage FSM state type,
// memory funct3 encodings, and lane/strobe helpers used to build store
// requests and to detect misaligned accesses.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned RD_W   = 5;

  // Memory access size/sign encodings (RISC-V funct3 style)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            load;
    logic            store;
    logic [2:0]      funct3;
    logic            branch;
  } control_info;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } mem_state_t;

  // Byte-lane write strobes for a store of the given size at byte offset off.
  function automatic logic [STRB_W-1:0] lane_strobe(input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic [STRB_W-1:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = '1;
    endcase
    return s;
  endfunction

  // Store data replicated across lanes so the strobes pick the right bytes.
  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0]      f3,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/half from the returned
// memory word and sign- or zero-extends it according to the load type.
// Ports: rdata (memory word), offset (byte address [1:0]),
//        funct3 (load type), data (extended 32-bit result).
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between execute and writeback.
// Accepts an instruction (CTR_INFO/EXEC_RD/ADDRESS/STORE_DATA) over an
// IN_VALID/IN_READY handshake, performs loads/stores on a req/gnt/rvalid
// data-memory port, and presents a registered writeback bundle
// (WB_ENABLE/WB_RD/WB_DATA/MISALIGNED) over OUT_VALID/OUT_READY.
// Misaligned accesses issue no memory request and complete with
// MISALIGNED=1, WB_ENABLE=0, WB_DATA=0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_AW = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  control_info       CTR_INFO,
  input  logic [31:0]       EXEC_RD,
  input  logic [31:0]       ADDRESS,
  input  logic [31:0]       STORE_DATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [3:0]        MEM_WSTRB,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [31:0]       MEM_RDATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              WB_ENABLE,
  output logic [4:0]        WB_RD,
  output logic [31:0]       WB_DATA,
  output logic              MISALIGNED
);

  mem_state_t        state_q, state_d;
  control_info       ctr_q, ctr_d;
  logic [31:0]       exec_rd_q, exec_rd_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_enable_q, wb_enable_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              misaligned_q, misaligned_d;

  logic        accept;
  logic        mem_op;
  logic        mis;
  logic        load_wb_en;
  logic [31:0] load_value;

  mem_stage_load_align u_load_align (
    .rdata  (MEM_RDATA),
    .offset (off_q),
    .funct3 (ctr_q.funct3),
    .data   (load_value)
  );

  assign IN_READY = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && OUT_READY);

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    exec_rd_d    = exec_rd_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = out_valid_q;
    wb_enable_d  = wb_enable_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misaligned_d = misaligned_q;

    accept     = IN_VALID && IN_READY;
    mem_op     = CTR_INFO.load || CTR_INFO.store;
    mis        = mem_op && is_misaligned(CTR_INFO.funct3, ADDRESS[1:0]);
    load_wb_en = ctr_q.load && (ctr_q.rd != '0) && !ctr_q.branch;

    case (state_q)
      ST_REQ: begin
        if (MEM_GNT) begin
          mem_req_d = 1'b0;
          if (ctr_q.store) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            wb_enable_d = 1'b0;
            wb_data_d   = exec_rd_q;
          end else if (MEM_RVALID) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            wb_enable_d = load_wb_en;
            wb_data_d   = load_value;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (MEM_RVALID) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          wb_enable_d = load_wb_en;
          wb_data_d   = load_value;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new accept (from IDLE, or from HOLD while the bundle drains)
    // overrides the drain transition above, so back-to-back has no bubble.
    if (accept) begin
      ctr_d        = CTR_INFO;
      exec_rd_d    = EXEC_RD;
      off_d        = ADDRESS[1:0];
      wb_rd_d      = CTR_INFO.rd;
      misaligned_d = 1'b0;
      if (mem_op && !mis) begin
        state_d     = ST_REQ;
        out_valid_d = 1'b0;
        mem_req_d   = 1'b1;
        mem_we_d    = CTR_INFO.store;
        mem_addr_d  = ADDRESS[MEM_AW+1:2];
        mem_wstrb_d = CTR_INFO.store ? lane_strobe(CTR_INFO.funct3, ADDRESS[1:0]) : '0;
        mem_wdata_d = store_lanes(CTR_INFO.funct3, STORE_DATA);
      end else begin
        state_d      = ST_HOLD;
        out_valid_d  = 1'b1;
        misaligned_d = mis;
        wb_enable_d  = (CTR_INFO.rd != '0) && !CTR_INFO.store && !CTR_INFO.branch && !mis;
        wb_data_d    = mis ? '0 : EXEC_RD;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      ctr_q        <= '0;
      exec_rd_q    <= '0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      wb_enable_q  <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      exec_rd_q    <= exec_rd_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      wb_enable_q  <= wb_enable_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign MEM_REQ    = mem_req_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WSTRB  = mem_wstrb_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign OUT_VALID  = out_valid_q;
  assign WB_ENABLE  = wb_enable_q;
  assign WB_RD      = wb_rd_q;
  assign WB_DATA    = wb_data_q;
  assign MISALIGNED = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instructions checked against a behavioural word-memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned AW = 30;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  control_info   CTR_INFO = '0;
  logic [31:0]   EXEC_RD = '0;
  logic [31:0]   ADDRESS = '0;
  logic [31:0]   STORE_DATA = '0;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_WSTRB;
  logic [31:0]   MEM_WDATA;
  logic          MEM_GNT = 1'b0;
  logic          MEM_RVALID = 1'b0;
  logic [31:0]   MEM_RDATA = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          WB_ENABLE;
  logic [4:0]    WB_RD;
  logic [31:0]   WB_DATA;
  logic          MISALIGNED;

  always #5 CLK = ~CLK;

  mem_stage #(.MEM_AW(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .CTR_INFO   (CTR_INFO),
    .EXEC_RD    (EXEC_RD),
    .ADDRESS    (ADDRESS),
    .STORE_DATA (STORE_DATA),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WSTRB  (MEM_WSTRB),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_GNT    (MEM_GNT),
    .MEM_RVALID (MEM_RVALID),
    .MEM_RDATA  (MEM_RDATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .WB_ENABLE  (WB_ENABLE),
    .WB_RD      (WB_RD),
    .WB_DATA    (WB_DATA),
    .MISALIGNED (MISALIGNED)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem_model [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_strobe(input logic [2:0] f3, input int unsigned off);
    int unsigned s;
    case (f3[1:0])
      2'b00:   s = 32'd1 << off;
      2'b01:   s = 32'd3 << off;
      default: s = 32'd15;
    endcase
    return 4'(s);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return (sd % 32'd256) * 32'h01010101;
      2'b01:   return (sd % 32'd65536) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word,
                                           input int unsigned off);
    logic [31:0] v;
    v = word >> (off * 8);
    case (f3)
      F3_B:    begin v = v % 32'd256;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      F3_H:    begin v = v % 32'd65536; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      F3_BU:   v = v % 32'd256;
      F3_HU:   v = v % 32'd65536;
      default: v = word;
    endcase
    return v;
  endfunction

  // Present one instruction for exactly one accepted cycle (call at a negedge).
  task automatic start_instr(input logic ld, input logic st, input logic br, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] addr,
                             input logic [31:0] sd);
    control_info ci;
    ci.rd = rd; ci.load = ld; ci.store = st; ci.funct3 = f3; ci.branch = br;
    IN_VALID = 1'b1; CTR_INFO = ci; EXEC_RD = ex; ADDRESS = addr; STORE_DATA = sd;
    @(negedge CLK);
    IN_VALID = 1'b0; CTR_INFO = '0;
    EXEC_RD = $urandom; ADDRESS = $urandom; STORE_DATA = $urandom;
  endtask

  task automatic do_instr(input logic ld, input logic st, input logic br, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] addr,
                          input logic [31:0] sd, input int unsigned gnt_dly,
                          input int unsigned rv_dly, input int unsigned rdy_dly);
    int unsigned off, idx, w;
    logic        mis, memop, exp_en;
    logic [31:0] exp_data, exp_wdata;
    logic [3:0]  exp_strb;
    off       = addr % 4;
    idx       = (addr / 4) % 16;
    mis       = (ld || st) && ((f3[1:0] == 2'b01 && off % 2 != 0) || (f3[1:0] == 2'b10 && off != 0));
    memop     = (ld || st) && !mis;
    exp_strb  = ref_strobe(f3, off);
    exp_wdata = ref_wdata(f3, sd);
    exp_en    = (rd != 0) && !st && !br && !mis;
    exp_data  = mis ? 32'd0 : (ld ? ref_load(f3, mem_model[idx], off) : ex);

    OUT_READY = 1'b0;
    w = 0;
    while (!IN_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    check_eq("in_ready_idle", 32'(IN_READY), 32'd1);
    start_instr(ld, st, br, f3, rd, ex, addr, sd);

    if (memop) begin
      for (int unsigned c = 0; c <= gnt_dly; c++) begin
        check_eq("req_high", 32'(MEM_REQ), 32'd1);
        check_eq("req_we", 32'(MEM_WE), 32'(st));
        check_eq("req_addr", 32'(MEM_ADDR), addr / 4);
        if (st) begin
          check_eq("req_wstrb", 32'(MEM_WSTRB), 32'(exp_strb));
          check_eq("req_wdata", MEM_WDATA, exp_wdata);
        end
        check_eq("req_in_ready", 32'(IN_READY), 32'd0);
        if (c == gnt_dly) begin
          MEM_GNT = 1'b1;
          if (ld && rv_dly == 0) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = mem_model[idx];
          end
        end
        @(negedge CLK);
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = $urandom;
      end
      if (ld && rv_dly > 0) begin
        for (int unsigned c = 1; c <= rv_dly; c++) begin
          check_eq("wait_req_low", 32'(MEM_REQ), 32'd0);
          check_eq("wait_out_valid", 32'(OUT_VALID), 32'd0);
          if (c == rv_dly) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = mem_model[idx];
          end
          @(negedge CLK);
          MEM_RVALID = 1'b0; MEM_RDATA = $urandom;
        end
      end
      if (st) begin
        for (int i = 0; i < 4; i++)
          if (exp_strb[i]) mem_model[idx][8*i +: 8] = exp_wdata[8*i +: 8];
      end
    end else begin
      check_eq("no_req", 32'(MEM_REQ), 32'd0);
    end

    check_eq("out_valid", 32'(OUT_VALID), 32'd1);
    check_eq("wb_rd", 32'(WB_RD), 32'(rd));
    check_eq("wb_enable", 32'(WB_ENABLE), 32'(exp_en));
    check_eq("misaligned", 32'(MISALIGNED), 32'(mis));
    if (!(st && !mis)) check_eq("wb_data", WB_DATA, exp_data);

    // Backpressure: outputs must hold; stray gnt/rvalid must be ignored.
    for (int unsigned c = 0; c < rdy_dly; c++) begin
      MEM_GNT = 1'($urandom_range(0, 1)); MEM_RVALID = 1'($urandom_range(0, 1));
      MEM_RDATA = $urandom;
      @(negedge CLK);
      check_eq("hold_valid", 32'(OUT_VALID), 32'd1);
      check_eq("hold_in_ready", 32'(IN_READY), 32'd0);
      check_eq("hold_wb_enable", 32'(WB_ENABLE), 32'(exp_en));
      check_eq("hold_req", 32'(MEM_REQ), 32'd0);
      if (!(st && !mis)) check_eq("hold_wb_data", WB_DATA, exp_data);
    end
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0;

    OUT_READY = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    OUT_READY = 1'b0;
    check_eq("out_drop", 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int unsigned kind;
    logic [2:0] ld_f3 [5];

    ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

    // Reset values
    repeat (2) @(negedge CLK);
    check_eq("rst_req", 32'(MEM_REQ), 32'd0);
    check_eq("rst_we", 32'(MEM_WE), 32'd0);
    check_eq("rst_addr", 32'(MEM_ADDR), 32'd0);
    check_eq("rst_wstrb", 32'(MEM_WSTRB), 32'd0);
    check_eq("rst_wdata", MEM_WDATA, 32'd0);
    check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check_eq("rst_wb_en", 32'(WB_ENABLE), 32'd0);
    check_eq("rst_wb_rd", 32'(WB_RD), 32'd0);
    check_eq("rst_wb_data", WB_DATA, 32'd0);
    check_eq("rst_misaligned", 32'(MISALIGNED), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_in_ready", 32'(IN_READY), 32'd1);

    // Directed cases
    do_instr(1'b0, 1'b0, 1'b0, F3_W, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 1);
    do_instr(1'b0, 1'b1, 1'b0, F3_B, 5'd1, 32'h0, 32'h103, 32'hAB, 2, 0, 1);
    mem_model[0] = 32'h00800000;
    do_instr(1'b1, 1'b0, 1'b0, F3_B, 5'd4, 32'h0, 32'h202, 32'h0, 0, 3, 1);
    do_instr(1'b1, 1'b0, 1'b0, F3_BU, 5'd4, 32'h0, 32'h202, 32'h0, 0, 3, 1);
    mem_model[4] = 32'hDEADBEEF;
    do_instr(1'b1, 1'b0, 1'b0, F3_W, 5'd6, 32'h0, 32'h10, 32'h0, 0, 0, 0);
    do_instr(1'b0, 1'b1, 1'b0, F3_W, 5'd2, 32'h0, 32'h6, 32'h1, 0, 0, 1);
    do_instr(1'b1, 1'b0, 1'b0, F3_HU, 5'd8, 32'h0, 32'h13, 32'h0, 0, 0, 1);
    do_instr(1'b0, 1'b0, 1'b0, F3_W, 5'd9, 32'hCAFE, 32'h0, 32'h0, 0, 0, 4);
    do_instr(1'b0, 1'b0, 1'b1, F3_W, 5'd9, 32'h77, 32'h0, 32'h0, 0, 0, 1);
    do_instr(1'b0, 1'b0, 1'b0, F3_W, 5'd0, 32'h99, 32'h0, 32'h0, 0, 0, 1);

    // Back-to-back: HOLD drains while the next instruction is accepted
    start_instr(1'b0, 1'b0, 1'b0, F3_W, 5'd3, 32'h111, 32'h0, 32'h0);
    check_eq("b2b_first_valid", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    #1;
    check_eq("b2b_in_ready", 32'(IN_READY), 32'd1);
    start_instr(1'b0, 1'b0, 1'b0, F3_W, 5'd7, 32'h55, 32'h0, 32'h0);
    OUT_READY = 1'b0;
    check_eq("b2b_second_valid", 32'(OUT_VALID), 32'd1);
    check_eq("b2b_second_rd", 32'(WB_RD), 32'd7);
    check_eq("b2b_second_data", WB_DATA, 32'h55);
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;

    // Reset while requesting
    start_instr(1'b1, 1'b0, 1'b0, F3_W, 5'd9, 32'h0, 32'h20, 32'h0);
    check_eq("rreq_req_before", 32'(MEM_REQ), 32'd1);
    RST = 1'b1;
    #1;
    check_eq("rreq_req_after", 32'(MEM_REQ), 32'd0);
    check_eq("rreq_out_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset while waiting for load data; late RVALID must be ignored
    start_instr(1'b1, 1'b0, 1'b0, F3_W, 5'd9, 32'h0, 32'h24, 32'h0);
    MEM_GNT = 1'b1;
    @(negedge CLK);
    MEM_GNT = 1'b0;
    check_eq("rwait_req_low", 32'(MEM_REQ), 32'd0);
    RST = 1'b1;
    #1;
    check_eq("rwait_req", 32'(MEM_REQ), 32'd0);
    check_eq("rwait_out_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h12345678;
    @(negedge CLK);
    MEM_RVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rwait_late_rvalid", 32'(OUT_VALID), 32'd0);
      check_eq("rwait_in_ready", 32'(IN_READY), 32'd1);
      @(negedge CLK);
    end

    // Randomized instructions
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
      case (kind)
        0: do_instr(1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 5'($urandom), $urandom, a,
                    $urandom, 0, 0, $urandom_range(0, 3));
        1: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          do_instr(1'b1, 1'b0, 1'b0, f3, 5'($urandom), $urandom, a, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        default: begin
          f3 = 3'($urandom_range(0, 2));
          do_instr(1'b0, 1'b1, 1'b0, f3, 5'($urandom), $urandom, a, $urandom,
                   $urandom_range(0, 3), 0, $urandom_range(0, 2));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
